fetch_stage: RTL and testbench

- Instruction-fetch stage of the 32-bit single-issue pipeline.
- Owns the PC register and the instruction-memory request/response handshake.
- Holds at most one outstanding request and a one-entry skid buffer.
- Presents Instruction/PC_Reg/PC_Next through the IF/ID register to the decode cycle; accepts stall and redirect (jump/branch/return target) back from downstream.

---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_skid_buffer.sv | 37 +++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch-stage state encoding, instruction field positions and default reset PC
package fetch_pkg;
  typedef enum logic [1:0] {RUN, WAIT, HOLD, HALT} state_t;
  localparam int STOP_BIT = 31;
  localparam int TYPE_MSB = 30;
  localparam int TYPE_LSB = 29;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {instr, pc} register (clk, rst, i_load/i_unload/i_clear, i_instr/i_pc in, o_valid/o_instr/o_pc out)
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end
  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC + imem handshake + skid + IF/ID (clk, rst, stall, redirect_*, imem_* in/out, if_valid/Instruction/PC_Reg/PC_Next/halted out)
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter bit          HALT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] Instruction,
  output logic [31:0] PC_Reg,
  output logic [31:0] PC_Next,
  output logic        halted
);
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_pc_next;
  logic        r_drop;
  logic        r_live;
  logic        r_halted;
  logic        w_accept;
  logic        w_free;
  logic        w_pending;
  logic        w_rsp;
  logic        w_drain;
  logic        w_ifid_load;
  logic        w_skid_load;
  logic        w_stop;
  logic        w_skid_valid;
  logic [31:0] w_ifid_instr;
  logic [31:0] w_ifid_pc;
  logic [31:0] w_skid_instr;
  logic [31:0] w_skid_pc;
  assign imem_req     = r_state == RUN && r_live && !(if_valid && stall);
  assign imem_addr    = r_pc;
  assign w_accept     = imem_req && imem_ready;
  assign w_free       = !if_valid || !stall;
  assign w_pending    = (r_state == WAIT && !imem_rvalid) || w_accept;
  assign w_rsp        = !redirect_valid && r_state == WAIT && imem_rvalid && !r_drop;
  assign w_drain      = !redirect_valid && r_state == HOLD && w_skid_valid && !stall;
  assign w_ifid_load  = (w_rsp && w_free) || w_drain;
  assign w_skid_load  = w_rsp && !w_free;
  assign w_ifid_instr = w_drain ? w_skid_instr : imem_rdata;
  assign w_ifid_pc    = w_drain ? w_skid_pc : r_req_pc;
  assign w_stop       = HALT_EN && w_ifid_load && w_ifid_instr[STOP_BIT];
  assign PC_Next      = r_pc_next;
  assign halted       = r_halted;
  fetch_skid_buffer u_ifid (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_ifid_load),
    .i_unload (!stall),
    .i_clear  (redirect_valid),
    .i_instr  (w_ifid_instr),
    .i_pc     (w_ifid_pc),
    .o_valid  (if_valid),
    .o_instr  (Instruction),
    .o_pc     (PC_Reg)
  );
  fetch_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_skid_load),
    .i_unload (w_drain),
    .i_clear  (redirect_valid),
    .i_instr  (imem_rdata),
    .i_pc     (r_req_pc),
    .o_valid  (w_skid_valid),
    .o_instr  (w_skid_instr),
    .o_pc     (w_skid_pc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_pc      <= RESET_PC;
      r_req_pc  <= '0;
      r_pc_next <= '0;
      r_drop    <= 1'b0;
      r_live    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_ifid_load) r_pc_next <= w_ifid_pc + 32'd1;
      if (redirect_valid) begin
        r_pc     <= redirect_target;
        r_halted <= 1'b0;
        r_drop   <= w_pending;
        r_state  <= w_pending ? WAIT : RUN;
      end else begin
        case (r_state)
          RUN: if (w_accept) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + 32'd1;
            r_state  <= WAIT;
          end
          WAIT: if (imem_rvalid) begin
            r_drop   <= 1'b0;
            r_halted <= w_stop;
            r_state  <= r_drop ? RUN : w_skid_load ? HOLD : w_stop ? HALT : RUN;
          end
          HOLD: if (!stall) begin
            r_halted <= w_stop;
            r_state  <= w_stop ? HALT : RUN;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, directed corner sequences and random traffic against a stream-level model
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] Instruction;
  logic [31:0] PC_Reg;
  logic [31:0] PC_Next;
  logic        halted;

  fetch_stage #(.RESET_PC(32'h0000_0000), .HALT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .Instruction(Instruction), .PC_Reg(PC_Reg),
    .PC_Next(PC_Next), .halted(halted)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lat = 1;
  int          cons_cnt = 0;
  int          pend_due = 0;
  bit          pend_on = 1'b0;
  logic [31:0] pend_addr = '0;
  bit          use_fixed = 1'b1;
  bit          stop_en = 1'b0;
  logic [31:0] fixed_word = 32'h0000_0021;
  logic [31:0] stop_addr = '0;
  logic [31:0] m_fetch = '0;
  logic [31:0] m_cons = '0;
  logic [31:0] prev_i = '0;
  logic [31:0] prev_pc = '0;
  bit          prev_hold = 1'b0;

  typedef struct {
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_ifv;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
    logic [31:0] exp_instr;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (stop_en && a == stop_addr) return 32'h8000_0000;
    if (use_fixed) return fixed_word;
    return {1'b0, a[30:0] ^ 31'h1555_AAAA};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] tg, input logic rdy);
    stall = s;
    redirect_valid = rv;
    redirect_target = tg;
    imem_ready = rdy;
    imem_rvalid = pend_on && cyc == pend_due;
    imem_rdata = imem_rvalid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic adv();
    if (!rst) begin
      if (prev_hold) begin
        chk("hold_valid", if_valid, 1);
        chk("hold_instr", Instruction, prev_i);
        chk("hold_pc", PC_Reg, prev_pc);
      end
      if (if_valid && stall) chk("req_gate", imem_req, 0);
      if (imem_req && imem_ready) begin
        chk("one_outstanding", pend_on, 0);
        chk("fetch_addr", imem_addr, m_fetch);
        m_fetch++;
      end
      if (if_valid && !stall) begin
        chk("cons_pc", PC_Reg, m_cons);
        chk("cons_instr", Instruction, mem_word(PC_Reg));
        chk("cons_next", PC_Next, PC_Reg + 32'd1);
        m_cons++;
        cons_cnt++;
      end
      if (redirect_valid) begin
        m_fetch = redirect_target;
        m_cons = redirect_target;
      end
      prev_hold = if_valid && stall && !redirect_valid;
      prev_i = Instruction;
      prev_pc = PC_Reg;
    end else begin
      m_fetch = '0;
      m_cons = '0;
      prev_hold = 1'b0;
    end
    if (imem_rvalid) pend_on = 1'b0;
    if (imem_req === 1'b1 && imem_ready) begin
      pend_on = 1'b1;
      pend_addr = imem_addr;
      pend_due = cyc + lat;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend_on = 1'b0;
    repeat (2) begin
      drive(0, 0, 0, 1);
      adv();
    end
    rst = 1'b0;
  endtask

  task automatic run_until_ifv(input int max);
    drive(0, 0, 0, 1);
    for (int i = 0; i < max && !if_valid; i++) begin
      adv();
      drive(0, 0, 0, 1);
    end
    chk("wait_ifv", if_valid, 1);
  endtask

  task automatic run_until_req(input int max);
    drive(0, 0, 0, 1);
    for (int i = 0; i < max && !imem_req; i++) begin
      adv();
      drive(0, 0, 0, 1);
    end
    chk("wait_req", imem_req, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    tbl[0] = '{0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0};
    tbl[1] = '{0, 1, 32'h0, 0, 32'h0, 32'h0, 32'h0};
    tbl[2] = '{0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{0, 1, 32'h1, 1, 32'h0, 32'h1, 32'h21};
    tbl[4] = '{0, 0, 32'h0, 0, 32'h0, 32'h1, 32'h21};
    tbl[5] = '{0, 1, 32'h2, 1, 32'h1, 32'h2, 32'h21};
    tbl[6] = '{0, 0, 32'h0, 0, 32'h1, 32'h2, 32'h21};
    tbl[7] = '{0, 1, 32'h3, 1, 32'h2, 32'h3, 32'h21};
    lat = 1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].stall, 0, 0, 1);
      chk($sformatf("t%0d_req", i), imem_req, tbl[i].exp_req);
      if (tbl[i].exp_req) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("t%0d_ifv", i), if_valid, tbl[i].exp_ifv);
      chk($sformatf("t%0d_pc", i), PC_Reg, tbl[i].exp_pc);
      chk($sformatf("t%0d_next", i), PC_Next, tbl[i].exp_next);
      chk($sformatf("t%0d_instr", i), Instruction, tbl[i].exp_instr);
      chk($sformatf("t%0d_halted", i), halted, 0);
      adv();
    end

    fixed_word = 32'h1234_5678;
    run_until_ifv(10);
    chk("stall_instr", Instruction, 32'h1234_5678);
    chk("stall_pc", PC_Reg, 32'h3);
    repeat (3) begin
      drive(1, 0, 0, 1);
      chk("stall_noreq", imem_req, 0);
      chk("stall_ifv", if_valid, 1);
      chk("stall_hold", Instruction, 32'h1234_5678);
      adv();
    end
    drive(0, 0, 0, 1);
    chk("release_ifv", if_valid, 1);
    chk("release_pc", PC_Reg, 32'h3);
    chk("release_req", imem_req, 1);
    adv();
    run_until_ifv(10);
    chk("release_next_pc", PC_Reg, 32'h4);

    lat = 2;
    run_until_req(10);
    adv();
    drive(0, 1, 32'h40, 1);
    chk("redir_wait_noreq", imem_req, 0);
    adv();
    drive(0, 0, 0, 1);
    chk("redir_drop_noreq", imem_req, 0);
    chk("redir_drop_ifv", if_valid, 0);
    adv();
    lat = 1;
    run_until_req(5);
    chk("redir_addr", imem_addr, 32'h40);
    run_until_ifv(10);
    chk("redir_pc", PC_Reg, 32'h40);
    chk("redir_next", PC_Next, 32'h41);

    stop_en = 1'b1;
    stop_addr = 32'h21;
    drive(0, 1, 32'h20, 1);
    adv();
    run_until_ifv(10);
    chk("pre_stop_pc", PC_Reg, 32'h20);
    adv();
    run_until_ifv(10);
    chk("stop_instr", Instruction, 32'h8000_0000);
    chk("stop_pc", PC_Reg, 32'h21);
    adv();
    repeat (4) begin
      drive(0, 0, 0, 1);
      chk("halt_flag", halted, 1);
      chk("halt_noreq", imem_req, 0);
      chk("halt_ifv", if_valid, 0);
      adv();
    end
    stop_en = 1'b0;
    drive(0, 1, 32'h10, 1);
    adv();
    drive(0, 0, 0, 1);
    chk("resume_halted", halted, 0);
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, 32'h10);

    drive(0, 1, 32'hFFFF_FFFF, 1);
    adv();
    run_until_ifv(10);
    chk("wrap_pc", PC_Reg, 32'hFFFF_FFFF);
    chk("wrap_next", PC_Next, 32'h0);
    run_until_req(5);
    chk("wrap_addr", imem_addr, 32'h0);

    lat = 2;
    run_until_req(5);
    adv();
    rst = 1'b1;
    drive(0, 0, 0, 1);
    adv();
    rst = 1'b0;
    drive(0, 0, 0, 1);
    chk("stale_ifv", if_valid, 0);
    chk("stale_noreq", imem_req, 0);
    adv();
    drive(0, 0, 0, 1);
    chk("post_rst_ifv", if_valid, 0);
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, 32'h0);
    lat = 1;
    adv();
    run_until_ifv(10);
    chk("post_rst_pc", PC_Reg, 32'h0);

    do_reset();
    use_fixed = 1'b0;
    c0 = cons_cnt;
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 3);
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0,
            $urandom_range(0, 1) ? $urandom : 32'hFFFF_FFF8 + $urandom_range(0, 7),
            $urandom_range(0, 9) < 7);
      adv();
    end
    drive(0, 0, 0, 1);
    chk("random_progress", (cons_cnt - c0) > 200, 1);
    chk("random_not_halted", halted, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
